// File: rtl/tff_bank_sequencer.sv
// Sequencer for a bank of external T flip-flops acting as a mod-M up/down counter.
// Commands (load, up N, down N, clear) arrive over a valid/ready handshake.
module tff_bank_sequencer #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_count,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_UP    = 2'd1;
  localparam logic [1:0] OP_DOWN  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH-1:0] inc_d;
  logic [WIDTH-1:0] dec_d;
  logic             over_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            rem_q  <= cmd_count;
            if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR)
              state_q <= S_LOAD;
            else if (cmd_count != '0)
              state_q <= S_RUN;
            else
              state_q <= S_DONE;
          end
        end
        S_LOAD: state_q <= S_DONE;
        S_RUN: begin
          rem_q <= rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1))
            state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Toggle mask is q ^ next_value; out-of-range values fold back into 0..M-1.
  always_comb begin
    t_out  = '0;
    wrap   = 1'b0;
    inc_d  = q_fb + WIDTH'(1);
    dec_d  = q_fb - WIDTH'(1);
    over_d = {1'b0, q_fb} >= MOD;
    unique case (state_q)
      S_LOAD: begin
        if (op_q == OP_CLEAR)
          t_out = q_fb;
        else
          t_out = q_fb ^ data_q;
      end
      S_RUN: begin
        if (op_q == OP_DOWN) begin
          if (q_fb == '0) begin
            t_out = TOP;
            wrap  = 1'b1;
          end else if (over_d) begin
            t_out = q_fb ^ TOP;
            wrap  = 1'b1;
          end else begin
            t_out = q_fb ^ dec_d;
          end
        end else begin
          if (q_fb >= TOP) begin
            t_out = q_fb;
            wrap  = 1'b1;
          end else begin
            t_out = q_fb ^ inc_d;
          end
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) & ~reset;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Bench for tff_bank_sequencer: directed scenarios plus random commands
// checked against an arithmetic mod-M counter model driving a T-flop bank.
module tb_tff_bank_sequencer;

  localparam int W = 4;
  localparam int M = 10;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_UP    = 2'd1;
  localparam logic [1:0] OP_DOWN  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] cmd_count;
  logic [W-1:0] t_out;
  logic         busy;
  logic         done;
  logic         wrap;
  logic [W-1:0] bank = '0;

  int n_cmp = 0;
  int n_err = 0;
  int ev = 0;

  always #5 clk = ~clk;

  always @(posedge clk) bank <= bank ^ t_out;

  tff_bank_sequencer #(.WIDTH(W), .MODULUS(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .q_fb      (bank),
    .t_out     (t_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One counting step of a mod-M counter; illegal values fold as specified.
  task automatic step(input logic [1:0] op, input int v,
                      output int nxt, output bit w);
    if (op == OP_DOWN) begin
      if (v == 0 || v >= M) begin
        nxt = M - 1;
        w = 1'b1;
      end else begin
        nxt = v - 1;
        w = 1'b0;
      end
    end else begin
      if (v >= M - 1) begin
        nxt = 0;
        w = 1'b1;
      end else begin
        nxt = v + 1;
        w = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input int data, input int cnt);
    int nxt;
    bit w;
    chk("ready_idle", {31'b0, cmd_ready}, 1);
    chk("tout_idle", {28'b0, t_out}, 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data[W-1:0];
    cmd_count = cnt[W-1:0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (op == OP_LOAD || op == OP_CLEAR) begin
      nxt = (op == OP_CLEAR) ? 0 : data;
      chk("busy_load", {31'b0, busy}, 1);
      chk("ready_load", {31'b0, cmd_ready}, 0);
      chk("done_load", {31'b0, done}, 0);
      @(negedge clk);
      chk("bank_load", {28'b0, bank}, nxt);
      ev = nxt;
    end else begin
      for (int k = 0; k < cnt; k++) begin
        step(op, ev, nxt, w);
        chk("wrap_step", {31'b0, wrap}, {31'b0, w});
        chk("done_run", {31'b0, done}, 0);
        chk("ready_run", {31'b0, cmd_ready}, 0);
        @(negedge clk);
        chk("bank_step", {28'b0, bank}, nxt);
        ev = nxt;
      end
    end
    chk("done_pulse", {31'b0, done}, 1);
    chk("tout_done", {28'b0, t_out}, 0);
    chk("wrap_done", {31'b0, wrap}, 0);
    @(negedge clk);
    chk("ready_back", {31'b0, cmd_ready}, 1);
    chk("done_clr", {31'b0, done}, 0);
    chk("busy_clr", {31'b0, busy}, 0);
    chk("bank_hold", {28'b0, bank}, ev);
  endtask

  initial begin
    int nxt;
    int partial;
    int op;
    int data;
    int cnt;
    bit w;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_data  = '0;
    cmd_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_tout", {28'b0, t_out}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_wrap", {31'b0, wrap}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 1);

    send(OP_LOAD, 7, 0);
    send(OP_UP, 0, 5);
    chk("up5_val", ev, 2);
    send(OP_DOWN, 0, 4);
    chk("dn4_val", ev, 8);
    send(OP_UP, 0, 0);
    chk("up0_val", ev, 8);

    // Reset lands during the third step of an UP 6.
    send(OP_LOAD, 3, 0);
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_count = 4'd6;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    partial = 5;
    chk("mid_bank", {28'b0, bank}, partial);
    reset = 1'b1;
    #1;
    chk("mid_tout", {28'b0, t_out}, 0);
    chk("mid_busy", {31'b0, busy}, 0);
    chk("mid_done", {31'b0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_ready", {31'b0, cmd_ready}, 1);
    chk("mid_hold", {28'b0, bank}, partial);
    @(negedge clk);
    chk("mid_nodone", {31'b0, done}, 0);
    chk("mid_hold2", {28'b0, bank}, partial);
    ev = partial;

    // CLEAR held valid through an UP 3 must wait for IDLE.
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_count = 4'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_CLEAR;
    for (int k = 0; k < 3; k++) begin
      chk("hold_ready", {31'b0, cmd_ready}, 0);
      step(OP_UP, ev, nxt, w);
      @(negedge clk);
      chk("hold_bank", {28'b0, bank}, nxt);
      ev = nxt;
    end
    chk("hold_done", {31'b0, done}, 1);
    @(negedge clk);
    chk("hold_idle", {31'b0, cmd_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("clr_busy", {31'b0, busy}, 1);
    @(negedge clk);
    chk("clr_bank", {28'b0, bank}, 0);
    chk("clr_done", {31'b0, done}, 1);
    ev = 0;
    @(negedge clk);
    chk("clr_ready", {31'b0, cmd_ready}, 1);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0)
        data = $urandom_range(M, 15);
      else
        data = $urandom_range(0, M - 1);
      cnt = $urandom_range(0, 12);
      send(op[1:0], data, cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tff_bank_sequencer.md
Name: tff_bank_sequencer

Overview:
- Controller that sequences a bank of WIDTH external T flip-flops: drives their per-bit toggle inputs (t_out) from their fed-back outputs (q_fb).
- Accepts commands over a valid/ready handshake: load, count up N steps, count down N steps, clear.
- Count is modulo MODULUS, so the bank behaves as a programmable mod-M up/down counter.
- Sits between the control logic of the ch6 counter exercises and the T flip-flop bank; the bank clocks on the same clk.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank (2..16).
- MODULUS, 10, count modulus; legal range 2..2**WIDTH; the count sequence is 0..MODULUS-1.

Ports:
- clk  input  1  rising-edge clock; shared with the T flip-flop bank.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_op  input  2  opcode: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
- cmd_data  input  WIDTH  LOAD target value; must be < MODULUS.
- cmd_count  input  WIDTH  number of steps for UP/DOWN.
- q_fb  input  WIDTH  Q outputs of the bank; must come straight from flops, no combinational path from t_out.
- t_out  output  WIDTH  toggle enables to the bank; a bank bit flips at the clk edge ending any cycle its t_out bit is 1.
- busy  output  1  high in LOAD, RUN and DONE.
- done  output  1  one-cycle pulse when a command completes.
- wrap  output  1  one-cycle pulse coinciding with a modulus wrap toggle.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, t_out=0, done=0, wrap=0, busy=0, remaining=0, op latch=0. cmd_ready=1 once reset is released.
- The bank's own reset is not driven by this block; q_fb is trusted as-is after reset.
- FSM states: IDLE, LOAD, RUN, DONE. All registers update on posedge clk.
- IDLE:
  - cmd_ready=1; t_out=0.
  - A handshake is cmd_valid & cmd_ready at a rising edge; it latches op, data and count.
  - LOAD or CLEAR -> LOAD.
  - UP or DOWN with cmd_count!=0 -> RUN with remaining=cmd_count.
  - UP or DOWN with cmd_count==0 -> DONE, with no toggles.
- LOAD (one cycle):
  - t_out = q_fb ^ target, where target = data for LOAD and 0 for CLEAR.
  - Next state is DONE. The bank holds target one cycle later.
- RUN: t_out is combinational from q_fb and the latched op.
  - UP, q_fb < MODULUS-1: t[0]=1; t[i] = &q_fb[i-1:0].
  - UP, q_fb >= MODULUS-1: t_out = q_fb, so the bank goes to 0; wrap=1 that cycle.
  - DOWN, q_fb == 0: t_out = MODULUS-1, so the bank goes to MODULUS-1; wrap=1 that cycle.
  - DOWN, q_fb >= MODULUS: t_out = q_fb ^ (MODULUS-1); wrap=1.
  - DOWN, otherwise: t[0]=1; t[i] = &~q_fb[i-1:0].
  - Each RUN cycle is one step: remaining decrements, and when remaining==1 the next state is DONE.
  - Latency: N steps take exactly N RUN cycles.
- DONE (one cycle): done=1, t_out=0, busy=1, cmd_ready=0; next state is IDLE.
- Minimum spacing between commands:
  - LOAD/CLEAR: 3 cycles from handshake to the next cmd_ready.
  - UP/DOWN: N+2 cycles.
  - cmd_count==0: 2 cycles.
- cmd_valid outside IDLE is ignored; the command is not accepted and not queued. The driver must hold cmd_valid and its fields until the handshake.
- Reset asserted mid-RUN: t_out drops to 0 immediately (asynchronously). The bank keeps its partially counted value. No done pulse is issued.
- Illegal cmd_data >= MODULUS: loaded verbatim. A following UP wraps to 0 on its first step; a following DOWN maps to MODULUS-1 on its first step. Both raise wrap.
- wrap and done are registered or decoded from state so they are glitch-free at the sampling edge. wrap may be combinational in RUN but must be stable before the rising edge.

Test Plan:
- Reset, then LOAD cmd_data=7 -> cmd_ready low for 2 cycles; bank reads 7; done pulses exactly once; cmd_ready returns 3 cycles after the handshake.
- Bank at 7, UP cmd_count=5 (MODULUS=10) -> q_fb sequence 8,9,0,1,2; wrap pulses on the 9->0 step only; done follows the fifth step.
- Bank at 2, DOWN cmd_count=4 -> sequence 1,0,9,8; wrap pulses on the 0->9 step; t_out=0 in IDLE afterwards.
- UP with cmd_count=0 -> no t_out activity; done one cycle after the handshake; bank unchanged.
- Reset pulse during the third step of UP cmd_count=6 -> t_out=0 within the same cycle; state IDLE; no done pulse; cmd_ready=1 after reset is released; bank holds the partial value.
- cmd_valid held high during RUN with cmd_op=CLEAR -> ignored until IDLE; then accepted; bank reads 0 after the LOAD cycle.
